// File: rtl/cus41_address_decoder.sv
// System 86 address decoder: main/sub 6809 chip selects and write strobes,
// vblank IRQ generation, Q-phase clock and frame watchdog driving nMRES.
module cus41_address_decoder (
    input  logic         CLK_6M,
    input  logic         rst,
    input  logic [15:11] MA,
    input  logic         nMWE,
    input  logic         nVBLA,
    input  logic         CLK_0,
    input  logic         CLK_1,
    input  logic         nSWE,
    input  logic         SA15,
    input  logic         SA14,
    input  logic         SA13,
    input  logic         SA12,
    input  logic         SA11,
    output logic         nMRES,
    output logic         nMINT,
    output logic         nSINT,
    output logic         Q,
    output logic         nMCS0,
    output logic         nMCS1,
    output logic         nMCS2,
    output logic         nMCS3,
    output logic         nMCS4,
    output logic         nMROM,
    output logic         nSND,
    output logic         nLTH0,
    output logic         nLTH1,
    output logic         SCS0,
    output logic         SCS1,
    output logic         SCS2,
    output logic         SCS3,
    output logic         SCS4,
    output logic         SROM
);

    localparam logic [3:0] WD_LIMIT   = 4'd8;
    localparam logic [5:0] RST_CYCLES = 6'd32;

    logic [4:0]  sa_blk;
    logic [31:0] mhit;
    logic [31:0] shit;
    logic        dec_en;
    logic        wr_m;
    logic        wr_s;
    logic        kick_m;
    logic        kick_s;
    logic        ack_m;
    logic        ack_s;

    assign sa_blk = {SA15, SA14, SA13, SA12, SA11};

    // One-hot 2 KB block hit vectors for both CPUs.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_blk
            assign mhit[gi] = (MA == 5'(gi));
            assign shit[gi] = (sa_blk == 5'(gi));
        end
    endgenerate

    assign dec_en = ~rst;
    assign wr_m   = dec_en & ~nMWE & CLK_0;
    assign wr_s   = dec_en & ~nSWE & CLK_1;

    assign nMCS0 = ~(dec_en & (|mhit[3:0]));
    assign nMCS1 = ~(dec_en & (|mhit[7:4]));
    assign nSND  = ~(dec_en & mhit[8]);
    assign nMCS2 = ~(dec_en & (|mhit[11:9]));
    assign nMCS3 = ~(dec_en & (|mhit[15:12]));
    assign nMROM = ~(dec_en & nMWE & (|mhit[31:16]));
    assign nLTH0 = ~(wr_m & mhit[18]);
    assign nLTH1 = ~(wr_m & mhit[19]);
    assign nMCS4 = ~(wr_m & mhit[20]);

    assign SCS0 = dec_en & (|shit[3:0]);
    assign SCS1 = dec_en & (|shit[7:4]);
    assign SCS2 = dec_en & (|shit[11:8]);
    assign SCS3 = dec_en & (|shit[15:12]);
    assign SROM = dec_en & nSWE & (|shit[31:16]);
    assign SCS4 = wr_s & shit[18];

    assign kick_m = wr_m & mhit[16];
    assign ack_m  = wr_m & mhit[17];
    assign kick_s = wr_s & shit[16];
    assign ack_s  = wr_s & shit[17];

    logic       vb_q;
    logic       mint_q, mint_d;
    logic       sint_q, sint_d;
    logic       km_q, km_d;
    logic       ks_q, ks_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] pulse_q, pulse_d;
    logic       nmres_q, nmres_d;
    logic       q_q;
    logic       vb_fall;

    always_comb begin
        vb_fall = vb_q & ~nVBLA;
        mint_d  = vb_fall ? 1'b1 : (ack_m ? 1'b0 : mint_q);
        sint_d  = vb_fall ? 1'b1 : (ack_s ? 1'b0 : sint_q);
        km_d    = km_q | kick_m;
        ks_d    = ks_q | kick_s;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        nmres_d = nmres_q;

        if (vb_fall && (cnt_q != WD_LIMIT)) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (km_q && ks_q) begin
            cnt_d = 4'd0;
            km_d  = kick_m;
            ks_d  = kick_s;
        end

        // nMRES stays low while the pulse counter is non-zero; the
        // watchdog state is held cleared for the whole pulse.
        if (pulse_q != 6'd0) begin
            pulse_d = pulse_q - 6'd1;
            nmres_d = 1'b0;
        end else if (cnt_q == WD_LIMIT) begin
            pulse_d = RST_CYCLES - 6'd1;
            nmres_d = 1'b0;
        end else begin
            nmres_d = 1'b1;
        end
        if ((pulse_q != 6'd0) || !nmres_q || (cnt_q == WD_LIMIT)) begin
            cnt_d = 4'd0;
            km_d  = 1'b0;
            ks_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            vb_q    <= 1'b1;
            mint_q  <= 1'b0;
            sint_q  <= 1'b0;
            km_q    <= 1'b0;
            ks_q    <= 1'b0;
            cnt_q   <= 4'd0;
            pulse_q <= RST_CYCLES;
            nmres_q <= 1'b0;
            q_q     <= 1'b0;
        end else begin
            vb_q    <= nVBLA;
            mint_q  <= mint_d;
            sint_q  <= sint_d;
            km_q    <= km_d;
            ks_q    <= ks_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            nmres_q <= nmres_d;
            q_q     <= CLK_0;
        end
    end

    assign nMRES = nmres_q;
    assign nMINT = ~mint_q;
    assign nSINT = ~sint_q;
    assign Q     = q_q;

endmodule

// File: tb/tb_cus41_address_decoder.sv
// Scoreboard bench for cus41_address_decoder: decode maps, write strobes,
// IRQ set/ack, Q phase, reset pulse and frame watchdog.
module tb_cus41_address_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ma, sa;
    logic       nmwe, nswe, nvbla, clk0, clk1;
    logic       nMRES, nMINT, nSINT, Q;
    logic       nMCS0, nMCS1, nMCS2, nMCS3, nMCS4, nMROM, nSND, nLTH0, nLTH1;
    logic       SCS0, SCS1, SCS2, SCS3, SCS4, SROM;
    logic [8:0] main_obs;
    logic [5:0] sub_obs;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    assign main_obs = {nMCS0, nMCS1, nSND, nMCS2, nMCS3, nMROM, nLTH0, nLTH1, nMCS4};
    assign sub_obs  = {SCS0, SCS1, SCS2, SCS3, SROM, SCS4};

    cus41_address_decoder dut (
        .CLK_6M(clk), .rst(rst), .MA(ma), .nMWE(nmwe), .nVBLA(nvbla),
        .CLK_0(clk0), .CLK_1(clk1), .nSWE(nswe),
        .SA15(sa[4]), .SA14(sa[3]), .SA13(sa[2]), .SA12(sa[1]), .SA11(sa[0]),
        .nMRES(nMRES), .nMINT(nMINT), .nSINT(nSINT), .Q(Q),
        .nMCS0(nMCS0), .nMCS1(nMCS1), .nMCS2(nMCS2), .nMCS3(nMCS3), .nMCS4(nMCS4),
        .nMROM(nMROM), .nSND(nSND), .nLTH0(nLTH0), .nLTH1(nLTH1),
        .SCS0(SCS0), .SCS1(SCS1), .SCS2(SCS2), .SCS3(SCS3), .SCS4(SCS4), .SROM(SROM)
    );

    // Order: {nMCS0,nMCS1,nSND,nMCS2,nMCS3,nMROM,nLTH0,nLTH1,nMCS4}, active low.
    function automatic logic [8:0] exp_main(input logic [4:0] blk, input logic nw, input logic e);
        logic [15:0] a;
        logic [8:0]  v;
        a = {blk, 11'd0};
        v = 9'h1FF;
        if (a < 16'h2000)      v[8] = 1'b0;
        else if (a < 16'h4000) v[7] = 1'b0;
        else if (a < 16'h4800) v[6] = 1'b0;
        else if (a < 16'h6000) v[5] = 1'b0;
        else if (a < 16'h8000) v[4] = 1'b0;
        else if (nw)           v[3] = 1'b0;
        if (!nw && e) begin
            if (a >= 16'h9000 && a < 16'h9800) v[2] = 1'b0;
            if (a >= 16'h9800 && a < 16'hA000) v[1] = 1'b0;
            if (a >= 16'hA000 && a < 16'hA800) v[0] = 1'b0;
        end
        return v;
    endfunction

    // Order: {SCS0,SCS1,SCS2,SCS3,SROM,SCS4}, active high.
    function automatic logic [5:0] exp_sub(input logic [4:0] blk, input logic nw, input logic e);
        logic [15:0] a;
        logic [5:0]  v;
        a = {blk, 11'd0};
        v = 6'd0;
        if (a < 16'h2000)      v[5] = 1'b1;
        else if (a < 16'h4000) v[4] = 1'b1;
        else if (a < 16'h6000) v[3] = 1'b1;
        else if (a < 16'h8000) v[2] = 1'b1;
        else if (nw)           v[1] = 1'b1;
        if (!nw && e && a >= 16'h9000 && a < 16'h9800) v[0] = 1'b1;
        return v;
    endfunction

    task automatic push(input string t, input logic [31:0] x);
        sb_t e;
        e.tag = t;
        e.exp = x;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        ma = 5'd0; sa = 5'd0; nmwe = 1'b1; nswe = 1'b1; clk0 = 1'b0; clk1 = 1'b0;
    endtask

    task automatic test_reset();
        sb_t e;
        logic [31:0] obs;
        int lows;
        rst = 1'b1; nvbla = 1'b1; idle(); clk0 = 1'b1;
        repeat (4) @(negedge clk);
        push("rst_status", 32'b0110);
        e = sb_q.pop_front(); obs = {28'd0, nMRES, nMINT, nSINT, Q}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%h exp=%h", e.tag, obs, e.exp); else pass_cnt++;
        push("rst_main_sel", 32'h1FF);
        e = sb_q.pop_front(); obs = {23'd0, main_obs}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%h exp=%h", e.tag, obs, e.exp); else pass_cnt++;
        push("rst_sub_sel", 32'h0);
        e = sb_q.pop_front(); obs = {26'd0, sub_obs}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%h exp=%h", e.tag, obs, e.exp); else pass_cnt++;
        rst = 1'b0; clk0 = 1'b0;
        push("rst_pulse_len", 32'd32);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (nMRES === 1'b0) lows++; else break;
        end
        e = sb_q.pop_front(); obs = 32'(lows); total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%0d exp=%0d", e.tag, obs, e.exp); else pass_cnt++;
        $display("reset: nMRES low for %0d cycles after release", lows);
    endtask

    task automatic test_q();
        sb_t e;
        logic [31:0] obs;
        clk0 = 1'b1;
        @(negedge clk);
        push("q_rise", 32'd1);
        e = sb_q.pop_front(); obs = {31'd0, Q}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%0d exp=%0d", e.tag, obs, e.exp); else pass_cnt++;
        clk0 = 1'b0; #1;
        push("q_lag", 32'd1);
        e = sb_q.pop_front(); obs = {31'd0, Q}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%0d exp=%0d", e.tag, obs, e.exp); else pass_cnt++;
        @(negedge clk);
        push("q_fall", 32'd0);
        e = sb_q.pop_front(); obs = {31'd0, Q}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%0d exp=%0d", e.tag, obs, e.exp); else pass_cnt++;
        $display("q: follows CLK_0 one cycle late");
    endtask

    task automatic test_main_decode();
        sb_t e;
        logic [31:0] obs;
        for (int i = 0; i < 32; i++) begin
            idle(); ma = 5'(i); #1;
            push("main_dec", {23'd0, exp_main(5'(i), 1'b1, 1'b0)});
            e = sb_q.pop_front(); obs = {23'd0, main_obs}; total_cnt++;
            if (obs !== e.exp) $display("FAIL %s ma=%0d got=%h exp=%h", e.tag, i, obs, e.exp);
            else pass_cnt++;
            $display("main read ma=%0d sel=%b", i, main_obs);
            @(negedge clk);
        end
    endtask

    task automatic test_main_strobes();
        sb_t e;
        logic [31:0] obs;
        for (int i = 16; i < 24; i++) begin
            for (int k = 0; k < 2; k++) begin
                idle(); ma = 5'(i); nmwe = 1'b0; clk0 = k[0]; #1;
                push("main_wr", {23'd0, exp_main(5'(i), 1'b0, k[0])});
                e = sb_q.pop_front(); obs = {23'd0, main_obs}; total_cnt++;
                if (obs !== e.exp) $display("FAIL %s ma=%0d e=%0d got=%h exp=%h", e.tag, i, k, obs, e.exp);
                else pass_cnt++;
                $display("main write ma=%0d clk0=%0d sel=%b", i, k, main_obs);
                @(negedge clk);
            end
        end
        idle();
    endtask

    task automatic test_sub_decode();
        sb_t e;
        logic [31:0] obs;
        for (int i = 0; i < 32; i++) begin
            idle(); sa = 5'(i); #1;
            push("sub_dec", {26'd0, exp_sub(5'(i), 1'b1, 1'b0)});
            e = sb_q.pop_front(); obs = {26'd0, sub_obs}; total_cnt++;
            if (obs !== e.exp) $display("FAIL %s sa=%0d got=%h exp=%h", e.tag, i, obs, e.exp);
            else pass_cnt++;
            $display("sub read sa=%0d sel=%b", i, sub_obs);
            @(negedge clk);
        end
        for (int i = 16; i < 22; i++) begin
            for (int k = 0; k < 2; k++) begin
                idle(); sa = 5'(i); nswe = 1'b0; clk1 = k[0]; #1;
                push("sub_wr", {26'd0, exp_sub(5'(i), 1'b0, k[0])});
                e = sb_q.pop_front(); obs = {26'd0, sub_obs}; total_cnt++;
                if (obs !== e.exp) $display("FAIL %s sa=%0d e=%0d got=%h exp=%h", e.tag, i, k, obs, e.exp);
                else pass_cnt++;
                $display("sub write sa=%0d clk1=%0d sel=%b", i, k, sub_obs);
                @(negedge clk);
            end
        end
        idle();
    endtask

    task automatic test_interrupts();
        sb_t e;
        logic [31:0] obs;
        idle(); nvbla = 1'b0; #1;
        push("irq_pre", 32'b11);
        e = sb_q.pop_front(); obs = {30'd0, nMINT, nSINT}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%b exp=%b", e.tag, obs[1:0], e.exp[1:0]); else pass_cnt++;
        @(negedge clk);
        push("irq_set", 32'b00);
        e = sb_q.pop_front(); obs = {30'd0, nMINT, nSINT}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%b exp=%b", e.tag, obs[1:0], e.exp[1:0]); else pass_cnt++;
        ma = 5'd17; nmwe = 1'b0; clk0 = 1'b1;
        @(negedge clk);
        push("irq_main_ack", 32'b10);
        e = sb_q.pop_front(); obs = {30'd0, nMINT, nSINT}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%b exp=%b", e.tag, obs[1:0], e.exp[1:0]); else pass_cnt++;
        idle(); sa = 5'd17; nswe = 1'b0; clk1 = 1'b1;
        @(negedge clk);
        push("irq_sub_ack", 32'b11);
        e = sb_q.pop_front(); obs = {30'd0, nMINT, nSINT}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%b exp=%b", e.tag, obs[1:0], e.exp[1:0]); else pass_cnt++;
        idle(); nvbla = 1'b1;
        @(negedge clk);
        nvbla = 1'b0;
        @(negedge clk);
        push("irq_set2", 32'b00);
        e = sb_q.pop_front(); obs = {30'd0, nMINT, nSINT}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%b exp=%b", e.tag, obs[1:0], e.exp[1:0]); else pass_cnt++;
        nvbla = 1'b1;
        @(negedge clk);
        nvbla = 1'b0;
        ma = 5'd17; nmwe = 1'b0; clk0 = 1'b1; sa = 5'd17; nswe = 1'b0; clk1 = 1'b1;
        @(negedge clk);
        push("irq_set_wins", 32'b00);
        e = sb_q.pop_front(); obs = {30'd0, nMINT, nSINT}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%b exp=%b", e.tag, obs[1:0], e.exp[1:0]); else pass_cnt++;
        @(negedge clk);
        push("irq_ack_both", 32'b11);
        e = sb_q.pop_front(); obs = {30'd0, nMINT, nSINT}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%b exp=%b", e.tag, obs[1:0], e.exp[1:0]); else pass_cnt++;
        idle(); nvbla = 1'b1;
        @(negedge clk);
        $display("irq: set, per-cpu ack and set-wins sequence done");
    endtask

    task automatic do_reset();
        sb_t e;
        logic [31:0] obs;
        idle(); nvbla = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push("rst_recover", 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (nMRES === 1'b1) break;
        end
        e = sb_q.pop_front(); obs = {31'd0, nMRES}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%0d exp=%0d", e.tag, obs, e.exp); else pass_cnt++;
    endtask

    task automatic test_watchdog_timeout();
        sb_t e;
        logic [31:0] obs;
        int early, lows, first;
        early = 0; lows = 0; first = -1;
        for (int f = 0; f < 7; f++) begin
            for (int c = 0; c < 8; c++) begin
                nvbla = (c < 2) ? 1'b0 : 1'b1;
                @(negedge clk);
                if (nMRES !== 1'b1) early++;
            end
        end
        push("wd_no_early", 32'd0);
        e = sb_q.pop_front(); obs = 32'(early); total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%0d exp=%0d", e.tag, obs, e.exp); else pass_cnt++;
        push("wd_pulse_len", 32'd32);
        for (int c = 0; c < 45; c++) begin
            nvbla = (c < 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (nMRES === 1'b0) begin
                lows++;
                if (first < 0) first = c;
            end
        end
        e = sb_q.pop_front(); obs = 32'(lows); total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%0d exp=%0d", e.tag, obs, e.exp); else pass_cnt++;
        push("wd_pulse_start", 32'd1);
        e = sb_q.pop_front(); obs = {31'd0, (first >= 0 && first <= 3)}; total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got first=%0d exp=0..3", e.tag, first); else pass_cnt++;
        $display("watchdog timeout: pulse started at %0d, low %0d cycles", first, lows);
    endtask

    task automatic test_watchdog_kicked();
        sb_t e;
        logic [31:0] obs;
        int lows;
        lows = 0;
        for (int f = 0; f < 20; f++) begin
            for (int c = 0; c < 10; c++) begin
                idle();
                nvbla = (c < 2) ? 1'b0 : 1'b1;
                if (c == 3) begin ma = 5'd16; nmwe = 1'b0; clk0 = 1'b1; end
                if (c == 5) begin sa = 5'd16; nswe = 1'b0; clk1 = 1'b1; end
                @(negedge clk);
                if (nMRES !== 1'b1) lows++;
            end
        end
        idle();
        push("wd_kicked", 32'd0);
        e = sb_q.pop_front(); obs = 32'(lows); total_cnt++;
        if (obs !== e.exp) $display("FAIL %s got=%0d low cycles exp=%0d", e.tag, obs, e.exp); else pass_cnt++;
        $display("watchdog kicked: nMRES low cycles over 20 frames = %0d", lows);
    endtask

    initial begin
        test_reset();
        test_q();
        test_main_decode();
        test_main_strobes();
        test_sub_decode();
        test_interrupts();
        do_reset();
        test_watchdog_timeout();
        test_watchdog_kicked();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
